// File: rtl/axi4_pkg.sv
// Shared AXI4 slave types: response codes, write/read FSM states, burst range helper.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package axi4_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // A burst touches words start_idx .. start_idx+len; it is servable only if the
  // last of those still lies inside the RAM. Evaluated at 32 bits so the sum
  // cannot wrap for any legal index/length combination.
  function automatic logic burst_in_range(input logic [31:0] start_idx,
                                          input logic [7:0]  len,
                                          input logic [31:0] depth);
    return (start_idx + {24'd0, len}) < depth;
  endfunction

endpackage

// File: rtl/axi4_mem_ram.sv
// Word-addressed RAM with one write port and one registered read port.
// Latency: read data appears one cycle after rd_vld; write lands on the same edge.
// Backpressure: none; rd_dat holds its value until the next rd_vld.
//
// Ports:
//   core_clk                 clock, rising edge
//   wr_vld/wr_addr/wr_dat    write strobe, word address, data
//   rd_vld/rd_addr           read strobe, word address
//   rd_dat                   registered read data (old data on a same-word write)
module axi4_mem_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 1024,
  parameter int RAM_AW       = 10
) (
  input  logic                  core_clk,
  input  logic                  wr_vld,
  input  logic [RAM_AW-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  rd_vld,
  input  logic [RAM_AW-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  // Contents are deliberately not reset; a storage array with reset would not
  // map onto a RAM macro.
  always_ff @(posedge core_clk) begin
    if (wr_vld) mem[wr_addr] <= wr_dat;
    if (rd_vld) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst memory slave with independent write (AW/W/B) and read (AR/R) paths.
// Latency: first RVALID one cycle after the AR handshake; BVALID on the edge after the last W beat.
// Backpressure: one burst per channel at a time; R and B outputs hold stable until RREADY/BREADY.
//
// Ports:
//   ACLK, ARESET                              clock, async active-high reset
//   AWADDR/AWLEN/AWSIZE/AWVALID/AWREADY       write address channel (AWSIZE ignored)
//   WDATA/WLAST/WVALID/WREADY                 write data channel
//   BRESP/BVALID/BREADY                       write response channel
//   ARADDR/ARLEN/ARSIZE/ARVALID/ARREADY       read address channel (ARSIZE ignored)
//   RDATA/RRESP/RLAST/RVALID/RREADY           read data channel
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int RAM_AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  // Size codes and byte-lane bits carry no information for a fixed-width word RAM.
  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE, ARSIZE, AWADDR[1:0], ARADDR[1:0]};

  // ---------------------------------------------------------------- write path
  w_state_t         w_state, w_state_nxt;
  logic             aw_rdy_q, aw_rdy_nxt;
  logic             w_rdy_q, w_rdy_nxt;
  logic             b_vld_q, b_vld_nxt;
  logic [1:0]       b_resp_q, b_resp_nxt;
  logic [IDX_W-1:0] w_idx_q, w_idx_nxt;
  logic [7:0]       w_cnt_q, w_cnt_nxt;
  logic [7:0]       w_len_q, w_len_nxt;
  logic             w_ok_q, w_ok_nxt;    // burst lies inside the RAM
  logic             w_err_q, w_err_nxt;  // WLAST seen before the final beat
  logic             ram_wr_vld;

  always_comb begin
    w_state_nxt = w_state;
    aw_rdy_nxt  = aw_rdy_q;
    w_rdy_nxt   = w_rdy_q;
    b_vld_nxt   = b_vld_q;
    b_resp_nxt  = b_resp_q;
    w_idx_nxt   = w_idx_q;
    w_cnt_nxt   = w_cnt_q;
    w_len_nxt   = w_len_q;
    w_ok_nxt    = w_ok_q;
    w_err_nxt   = w_err_q;
    ram_wr_vld  = 1'b0;

    case (w_state)
      W_IDLE: begin
        aw_rdy_nxt = 1'b1;
        if (AWVALID && aw_rdy_q) begin
          aw_rdy_nxt  = 1'b0;
          w_rdy_nxt   = 1'b1;
          w_idx_nxt   = AWADDR[ADDR_WIDTH-1:2];
          w_len_nxt   = AWLEN;
          w_cnt_nxt   = 8'd0;
          w_ok_nxt    = burst_in_range(32'(AWADDR[ADDR_WIDTH-1:2]), AWLEN, 32'(MEMORY_DEPTH));
          w_err_nxt   = 1'b0;
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && w_rdy_q) begin
          ram_wr_vld = w_ok_q;
          w_idx_nxt  = w_idx_q + IDX_W'(1);
          w_cnt_nxt  = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) begin
            // The beat count, not WLAST, ends the burst; WLAST only grades it.
            w_rdy_nxt   = 1'b0;
            b_vld_nxt   = 1'b1;
            b_resp_nxt  = (w_ok_q && !w_err_q && WLAST) ? OKAY : SLVERR;
            w_state_nxt = W_RESP;
          end else if (WLAST) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          b_vld_nxt   = 1'b0;
          b_resp_nxt  = OKAY;
          aw_rdy_nxt  = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state  <= W_IDLE;
      aw_rdy_q <= 1'b0;
      w_rdy_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      b_resp_q <= OKAY;
      w_idx_q  <= '0;
      w_cnt_q  <= '0;
      w_len_q  <= '0;
      w_ok_q   <= 1'b0;
      w_err_q  <= 1'b0;
    end else begin
      w_state  <= w_state_nxt;
      aw_rdy_q <= aw_rdy_nxt;
      w_rdy_q  <= w_rdy_nxt;
      b_vld_q  <= b_vld_nxt;
      b_resp_q <= b_resp_nxt;
      w_idx_q  <= w_idx_nxt;
      w_cnt_q  <= w_cnt_nxt;
      w_len_q  <= w_len_nxt;
      w_ok_q   <= w_ok_nxt;
      w_err_q  <= w_err_nxt;
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_t         r_state, r_state_nxt;
  logic             ar_rdy_q, ar_rdy_nxt;
  logic             r_vld_q, r_vld_nxt;
  logic             r_last_q, r_last_nxt;
  logic [1:0]       r_resp_q, r_resp_nxt;
  logic [IDX_W-1:0] r_idx_q, r_idx_sel;   // r_idx_sel: word fetched this edge
  logic [7:0]       r_cnt_q, r_cnt_nxt;
  logic [7:0]       r_len_q, r_len_nxt;
  logic             r_ok_q, r_ok_nxt;
  logic             ar_ok;
  logic             ram_rd_vld;
  logic [DATA_WIDTH-1:0] ram_rd_dat;

  assign ar_ok = burst_in_range(32'(ARADDR[ADDR_WIDTH-1:2]), ARLEN, 32'(MEMORY_DEPTH));

  always_comb begin
    r_state_nxt = r_state;
    ar_rdy_nxt  = ar_rdy_q;
    r_vld_nxt   = r_vld_q;
    r_last_nxt  = r_last_q;
    r_resp_nxt  = r_resp_q;
    r_idx_sel   = r_idx_q;
    r_cnt_nxt   = r_cnt_q;
    r_len_nxt   = r_len_q;
    r_ok_nxt    = r_ok_q;
    ram_rd_vld  = 1'b0;

    case (r_state)
      R_IDLE: begin
        ar_rdy_nxt = 1'b1;
        if (ARVALID && ar_rdy_q) begin
          ar_rdy_nxt  = 1'b0;
          r_idx_sel   = ARADDR[ADDR_WIDTH-1:2];
          ram_rd_vld  = ar_ok;
          r_vld_nxt   = 1'b1;
          r_last_nxt  = (ARLEN == 8'd0);
          r_resp_nxt  = ar_ok ? OKAY : SLVERR;
          r_cnt_nxt   = 8'd0;
          r_len_nxt   = ARLEN;
          r_ok_nxt    = ar_ok;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (r_vld_q && RREADY) begin
          if (r_last_q) begin
            r_vld_nxt   = 1'b0;
            r_last_nxt  = 1'b0;
            r_resp_nxt  = OKAY;
            ar_rdy_nxt  = 1'b1;
            r_state_nxt = R_IDLE;
          end else begin
            // Prefetch the next word on the accepting edge so the next beat is
            // presented without a bubble.
            r_idx_sel  = r_idx_q + IDX_W'(1);
            ram_rd_vld = r_ok_q;
            r_cnt_nxt  = r_cnt_q + 8'd1;
            r_last_nxt = ((r_cnt_q + 8'd1) == r_len_q);
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state  <= R_IDLE;
      ar_rdy_q <= 1'b0;
      r_vld_q  <= 1'b0;
      r_last_q <= 1'b0;
      r_resp_q <= OKAY;
      r_idx_q  <= '0;
      r_cnt_q  <= '0;
      r_len_q  <= '0;
      r_ok_q   <= 1'b0;
    end else begin
      r_state  <= r_state_nxt;
      ar_rdy_q <= ar_rdy_nxt;
      r_vld_q  <= r_vld_nxt;
      r_last_q <= r_last_nxt;
      r_resp_q <= r_resp_nxt;
      r_idx_q  <= r_idx_sel;
      r_cnt_q  <= r_cnt_nxt;
      r_len_q  <= r_len_nxt;
      r_ok_q   <= r_ok_nxt;
    end
  end

  // ------------------------------------------------------------------- storage
  axi4_mem_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .RAM_AW       (RAM_AW)
  ) u_ram (
    .core_clk (ACLK),
    .wr_vld   (ram_wr_vld),
    .wr_addr  (w_idx_q[RAM_AW-1:0]),
    .wr_dat   (WDATA),
    .rd_vld   (ram_rd_vld),
    .rd_addr  (r_idx_sel[RAM_AW-1:0]),
    .rd_dat   (ram_rd_dat)
  );

  // The RAM read register has no reset, so gating here gives RDATA=0 in reset,
  // between bursts and for out-of-range bursts.
  assign RDATA   = (r_vld_q && r_ok_q) ? ram_rd_dat : '0;
  assign RRESP   = r_resp_q;
  assign RLAST   = r_last_q;
  assign RVALID  = r_vld_q;
  assign ARREADY = ar_rdy_q;
  assign AWREADY = aw_rdy_q;
  assign WREADY  = w_rdy_q;
  assign BVALID  = b_vld_q;
  assign BRESP   = b_resp_q;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave with a reference memory and R/B scoreboards.
// Latency: checks the one-cycle AR-to-RVALID latency and AWREADY after reset.
// Backpressure: exercises RREADY and BREADY stalls.
module tb_axi4_mem_slave;
  import axi4_pkg::*;

  localparam int TMO = 100;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [15:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  always #5 ACLK = ~ACLK;

  axi4_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEMORY_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model [0:1023];
  rbeat_t      r_q[$];
  logic [1:0]  b_q[$];
  logic [31:0] wbeats[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic tb_in_range(input logic [15:0] addr, input int len);
    return (int'(addr[15:2]) + len) < 1024;
  endfunction

  // Drives one write burst from wbeats; WLAST is raised on beat last_beat.
  task automatic do_write(input logic [15:0] addr, input int len, input int last_beat,
                          input int bdelay);
    logic ok;
    int   t;
    ok = tb_in_range(addr, len);
    b_q.push_back((ok && last_beat == len) ? OKAY : SLVERR);
    if (ok) for (int i = 0; i <= len; i++) model[int'(addr[15:2]) + i] = wbeats[i];

    AWADDR = addr; AWLEN = 8'(len); AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < TMO) begin tick; t++; end
    chk("awready_seen", 32'(AWREADY), 1);
    tick;
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      WDATA = wbeats[i]; WLAST = (i == last_beat); WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < TMO) begin tick; t++; end
      chk("wready_seen", 32'(WREADY), 1);
      tick;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    t = 0;
    while (!BVALID && t < TMO) begin tick; t++; end
    chk("bvalid_seen", 32'(BVALID), 1);
    repeat (bdelay) begin
      tick;
      chk("bvalid_hold", 32'(BVALID), 1);
    end
    BREADY = 1'b1;
    chk("bresp", 32'(BRESP), 32'(b_q.pop_front()));
    tick;
    BREADY = 1'b0;
    chk("bvalid_clear", 32'(BVALID), 0);
    chk("awready_back", 32'(AWREADY), 1);
  endtask

  // Reads one burst; beat stall_beat is held off with RREADY=0 for stall_cyc cycles.
  task automatic do_read(input logic [15:0] addr, input int len, input int stall_beat,
                         input int stall_cyc);
    logic   ok;
    int     t;
    rbeat_t e;
    ok = tb_in_range(addr, len);
    for (int i = 0; i <= len; i++) begin
      if (ok) e.dat = model[int'(addr[15:2]) + i];
      else    e.dat = 32'h0;
      e.resp = ok ? OKAY : SLVERR;
      e.last = (i == len);
      r_q.push_back(e);
    end

    ARADDR = addr; ARLEN = 8'(len); ARVALID = 1'b1; RREADY = 1'b1;
    t = 0;
    while (!ARREADY && t < TMO) begin tick; t++; end
    chk("arready_seen", 32'(ARREADY), 1);
    tick;
    ARVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i == 0) chk("r_first_latency", 32'(RVALID), 1);
      t = 0;
      while (!RVALID && t < TMO) begin tick; t++; end
      chk("rvalid_seen", 32'(RVALID), 1);
      if (i == stall_beat) begin
        RREADY = 1'b0;
        repeat (stall_cyc) begin
          tick;
          chk("rvalid_stall", 32'(RVALID), 1);
          chk("rdata_stall", RDATA, r_q[0].dat);
          chk("rlast_stall", 32'(RLAST), 32'(r_q[0].last));
        end
        RREADY = 1'b1;
      end
      e = r_q.pop_front();
      chk("rdata", RDATA, e.dat);
      chk("rresp", 32'(RRESP), 32'(e.resp));
      chk("rlast", 32'(RLAST), 32'(e.last));
      tick;
    end
    RREADY = 1'b0;
    chk("rvalid_clear", 32'(RVALID), 0);
    chk("arready_back", 32'(ARREADY), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    ARESET = 1'b1;
    AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWVALID = 1'b0;
    WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) tick;

    // Reset state
    chk("rst_awready", 32'(AWREADY), 0);
    chk("rst_wready", 32'(WREADY), 0);
    chk("rst_bvalid", 32'(BVALID), 0);
    chk("rst_bresp", 32'(BRESP), 0);
    chk("rst_arready", 32'(ARREADY), 0);
    chk("rst_rvalid", 32'(RVALID), 0);
    chk("rst_rlast", 32'(RLAST), 0);
    chk("rst_rresp", 32'(RRESP), 0);
    chk("rst_rdata", RDATA, 0);
    ARESET = 1'b0;
    chk("awready_at_release", 32'(AWREADY), 0);
    tick;
    chk("awready_after_release", 32'(AWREADY), 1);
    chk("arready_after_release", 32'(ARREADY), 1);

    // Single write then read
    wbeats.delete(); wbeats.push_back(32'hDEADBEEF);
    do_write(16'h0010, 0, 0, 0);
    do_read(16'h0010, 0, -1, 0);

    // Four-beat burst with B and R backpressure
    wbeats.delete();
    for (int i = 1; i <= 4; i++) wbeats.push_back(32'(i));
    do_write(16'h0100, 3, 3, 3);
    do_read(16'h0100, 3, 1, 5);

    // Out of range: seed the last word, then a burst running past the end
    wbeats.delete(); wbeats.push_back(32'h5A5A5A5A);
    do_write(16'h0FFC, 0, 0, 0);
    wbeats.delete(); wbeats.push_back(32'h11111111); wbeats.push_back(32'h22222222);
    do_write(16'h0FFC, 1, 1, 0);
    do_read(16'h0FFC, 0, -1, 0);
    do_read(16'h0FFC, 1, -1, 0);

    // Early WLAST: all beats land, response is SLVERR
    wbeats.delete();
    for (int i = 0; i < 3; i++) wbeats.push_back(32'hA0 + 32'(i));
    do_write(16'h0200, 2, 1, 0);
    do_read(16'h0200, 2, -1, 0);

    // Reset during beat 1 of a 4-beat write
    AWADDR = 16'h0300; AWLEN = 8'd3; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < TMO) begin tick; t++; end
    chk("mid_awready_seen", 32'(AWREADY), 1);
    tick;
    AWVALID = 1'b0;
    WDATA = 32'hC0; WLAST = 1'b0; WVALID = 1'b1;
    chk("mid_wready_beat0", 32'(WREADY), 1);
    tick;
    model[16'h0300 >> 2] = 32'hC0;
    WDATA = 32'hC1;
    #2;
    ARESET = 1'b1;
    #1;
    chk("mid_rst_awready", 32'(AWREADY), 0);
    chk("mid_rst_wready", 32'(WREADY), 0);
    chk("mid_rst_bvalid", 32'(BVALID), 0);
    chk("mid_rst_rvalid", 32'(RVALID), 0);
    WVALID = 1'b0;
    tick;
    ARESET = 1'b0;
    chk("mid_awready_at_release", 32'(AWREADY), 0);
    tick;
    chk("mid_awready_after_release", 32'(AWREADY), 1);
    do_read(16'h0300, 0, -1, 0);
    wbeats.delete(); wbeats.push_back(32'h77777777);
    do_write(16'h0304, 0, 0, 0);
    do_read(16'h0304, 0, -1, 0);

    chk("scoreboard_drained", 32'(r_q.size() + b_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
